// File: rtl/merge_2_s_l_pkg.sv
// Shared types for the store/load completion join: opcode constants, FSM states and channel ids.
// Also holds the round-robin pick used when both completion paths request at once.
package merge_2_s_l_pkg;

   localparam logic [6:0] S_TYPE    = 7'b0100011;
   localparam logic [6:0] I_TYPE_LD = 7'b0000011;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_LO, ACK_SRC} state_e;

   typedef enum logic {CH_ST, CH_LD} chan_e;

   // On contention the channel not served last wins; a lone request always wins.
   function automatic chan_e pick_chan(input logic rq1, input logic rq2, input chan_e last);
      if (rq1 && rq2) begin
         return (last == CH_ST) ? CH_LD : CH_ST;
      end else if (rq2) begin
         return CH_LD;
      end
      return CH_ST;
   endfunction

endpackage

// File: rtl/merge_2_s_l_sync.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_ff #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/merge_2_s_l.sv
// Joins store (ch1) and load (ch2) completion handshakes onto one 4-phase channel to writeback.
// All handshake inputs are asynchronous to clk and are synchronized before the FSM sees them.
module merge_2_s_l
   import merge_2_s_l_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned RD_W        = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        opcode,
   input  logic              req_in_1,
   output logic              ack_out_1,
   input  logic              req_in_2,
   output logic              ack_out_2,
   input  logic [DATA_W-1:0] data_in_2,
   input  logic [RD_W-1:0]   rd_in_2,
   output logic              req_out,
   input  logic              ack_in,
   output logic [DATA_W-1:0] data_out,
   output logic [RD_W-1:0]   rd_out,
   output logic              is_load,
   output logic              sel_err
);

   logic rq1, rq2, ak;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rq1 (
      .clk (clk),
      .rst (rst),
      .d_i (req_in_1),
      .q_o (rq1)
   );

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rq2 (
      .clk (clk),
      .rst (rst),
      .d_i (req_in_2),
      .q_o (rq2)
   );

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ak (
      .clk (clk),
      .rst (rst),
      .d_i (ack_in),
      .q_o (ak)
   );

   state_e            state_q, state_d;
   chan_e             grant_q, grant_d;
   chan_e             last_q, last_d;
   logic              req_q, req_d;
   logic              ack1_q, ack1_d;
   logic              ack2_q, ack2_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              is_load_q, is_load_d;
   logic              sel_err_q, sel_err_d;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      req_d     = req_q;
      ack1_d    = ack1_q;
      ack2_d    = ack2_q;
      data_d    = data_q;
      rd_d      = rd_q;
      is_load_d = is_load_q;
      sel_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (rq1 || rq2) begin
               grant_d = pick_chan(rq1, rq2, last_q);
               last_d  = grant_d;
               req_d   = 1'b1;
               state_d = REQ;
               if (grant_d == CH_LD) begin
                  data_d    = data_in_2;
                  rd_d      = rd_in_2;
                  is_load_d = 1'b1;
                  sel_err_d = (opcode != I_TYPE_LD);
               end else begin
                  data_d    = '0;
                  rd_d      = '0;
                  is_load_d = 1'b0;
                  sel_err_d = (opcode != S_TYPE);
               end
            end
         end
         REQ: begin
            if (ak) begin
               req_d   = 1'b0;
               state_d = WAIT_LO;
            end
         end
         WAIT_LO: begin
            // Source ack only after writeback has fully returned to zero.
            if (!ak) begin
               if (grant_q == CH_LD) begin
                  ack2_d = 1'b1;
               end else begin
                  ack1_d = 1'b1;
               end
               state_d = ACK_SRC;
            end
         end
         ACK_SRC: begin
            if ((grant_q == CH_LD) ? !rq2 : !rq1) begin
               ack1_d  = 1'b0;
               ack2_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= CH_ST;
         last_q    <= CH_ST;
         req_q     <= 1'b0;
         ack1_q    <= 1'b0;
         ack2_q    <= 1'b0;
         data_q    <= '0;
         rd_q      <= '0;
         is_load_q <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         req_q     <= req_d;
         ack1_q    <= ack1_d;
         ack2_q    <= ack2_d;
         data_q    <= data_d;
         rd_q      <= rd_d;
         is_load_q <= is_load_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign req_out   = req_q;
   assign ack_out_1 = ack1_q;
   assign ack_out_2 = ack2_q;
   assign data_out  = data_q;
   assign rd_out    = rd_q;
   assign is_load   = is_load_q;
   assign sel_err   = sel_err_q;

endmodule

// File: doc/merge_2_s_l.md
Name: merge_2_s_l

Overview:
- Clocked join for the store/load fork: collects the completion handshake from the store path (channel 1) and the load path (channel 2) and merges them onto one 4-phase req/ack channel toward writeback.
- Load completions carry result data and destination register; store completions carry none.
- Source-side and sink-side req/ack are asynchronous to clk; all are synchronized internally.

Parameters:
- DATA_W, 32, width of load result data
- RD_W, 5, width of destination register index
- SYNC_STAGES, 2, flops per synchronizer (legal 2..4)

Ports:
- clk  input  1  single clock
- rst  input  1  reset, asynchronous, active-high
- opcode  input  7  opcode of the in-flight instruction: store = 7'b0100011, load = 7'b0000011
- req_in_1  input  1  store-path completion request (4-phase)
- ack_out_1  output  1  acknowledge to store path
- req_in_2  input  1  load-path completion request (4-phase)
- ack_out_2  output  1  acknowledge to load path
- data_in_2  input  DATA_W  load result, stable while req_in_2 high
- rd_in_2  input  RD_W  load destination register, stable while req_in_2 high
- req_out  output  1  merged request to writeback
- ack_in  input  1  acknowledge from writeback
- data_out  output  DATA_W  captured data; zero for store
- rd_out  output  RD_W  captured rd; zero for store
- is_load  output  1  1 = current transfer is a load completion
- sel_err  output  1  one-cycle pulse on an opcode/channel mismatch

Behaviour:
- Reset values: all outputs 0, FSM IDLE, last_grant = 1 (channel 1), synchronizers cleared.
- req_in_1, req_in_2 and ack_in each pass through SYNC_STAGES flops; the FSM sees only synchronized values (rq1, rq2, ak).
- IDLE:
  - If rq1 or rq2 is high, grant one channel.
  - Capture data_out/rd_out: from channel 2 for a load grant, zero for a store grant. Set is_load.
  - Set req_out = 1 and go to REQ.
  - If both are high, grant the channel not equal to last_grant, then update last_grant.
- REQ: hold req_out = 1 until ak = 1, then req_out = 0 and go to WAIT_LO.
- WAIT_LO: when ak = 0, raise ack_out_k for the granted channel and go to ACK_SRC.
- ACK_SRC: when the granted rq_k = 0, drop ack_out_k and go to IDLE. The other channel's pending request is served from IDLE on the following cycle.
- Latency:
  - req_out rises SYNC_STAGES+1 rising edges after req_in_k rises, provided it is stable before the first sample.
  - Every subsequent FSM step is SYNC_STAGES+1 edges after the corresponding input edge.
- data_out, rd_out and is_load are registered at grant and held stable from req_out rise until the next grant.
- sel_err pulses in the grant cycle when:
  - channel 1 is granted while opcode ≠ S_type, or
  - channel 2 is granted while opcode ≠ I_type_ld.
  - The transfer still completes.
- Never more than one ack_out_k high. ack_out_k never rises while req_out is high.
- Reset mid-transfer: outputs drop to 0 asynchronously and the FSM returns to IDLE. A source still holding req high is re-served from scratch after reset deassertion; the data is re-captured.
- A req_in_k glitch shorter than one clock period is not required to be captured. Sources are required to hold req until acked.

Decomposition:
- Shared package, extended from the split block's package:
  - opcode constants S_TYPE = 7'b0100011, I_TYPE_LD = 7'b0000011
  - FSM state typedef {IDLE, REQ, WAIT_LO, ACK_SRC}
  - channel enum {CH_ST, CH_LD}
- One sub-module: sync_ff (parameterised SYNC_STAGES, 1-bit, async reset to 0), instantiated three times.

Test Plan:
- Store only, opcode = 7'b0100011: raise req_in_1 → req_out high at edge 3 (SYNC_STAGES = 2), is_load = 0, data_out = 0. Then ack_in 1 → 0 → ack_out_1 = 1. Drop req_in_1 → ack_out_1 = 0, FSM IDLE.
- Load only, opcode = 7'b0000011, data_in_2 = 32'hDEADBEEF, rd_in_2 = 5'd7: full 4-phase cycle → data_out = 32'hDEADBEEF, rd_out = 7, is_load = 1, ack_out_2 pulses; sel_err stays 0.
- Both requests raised on the same edge after reset: channel 2 is granted first (last_grant = 1), then channel 1 without a new req edge. ack_out_1 and ack_out_2 are never high together.
- Channel 1 request with opcode = 7'b0000011 → sel_err high for exactly one cycle at grant; the transfer completes normally.
- Assert rst while in REQ with req_in_2 held high → req_out and ack_out_2 go to 0 immediately. After release, req_out re-rises SYNC_STAGES+1 edges later with re-captured data.
- Slow sink: ack_in delayed 20 cycles → req_out, data_out and rd_out remain stable throughout; no ack_out_k is issued early.
